alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Execute stage fed directly by the ALU control decoder's 4-bit code. Performs the selected operation on two register operands.
- Logic/arithmetic ops complete in one cycle. Shift-right-logical runs serially, one bit per cycle, to save area.
- A start/busy/done handshake lets the surrounding datapath stall while a shift is in flight.
- Result and zero flag are registered and held until the next completion.

Parameters:
- WIDTH, 32, operand/result width in bits (must be a power of two, >= 8).
- SHAMT_W, $clog2(WIDTH), localparam: shift-amount width, taken from B_in[SHAMT_W-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- start_in  in  1  request; sampled only when busy_out=0.
- ALUControl_in  in  4  operation code, sampled with start_in.
- A_in  in  WIDTH  operand A, sampled with start_in.
- B_in  in  WIDTH  operand B or shift amount, sampled with start_in.
- result_out  out  WIDTH  registered result, held between completions.
- zero_out  out  1  registered (result_out == 0).
- busy_out  out  1  high while a serial shift is in progress.
- done_out  out  1  one-cycle pulse; result_out/zero_out updated in the same cycle.

Behaviour:
- Reset values (async, rst_n low): state=IDLE, result_out=0, zero_out=1, busy_out=0, done_out=0, shift count=0.
- Operation codes:
  - 0000 AND, 0001 OR.
  - 0010 ADD, 0110 SUB: modulo 2^WIDTH, carry/overflow discarded.
  - 0111 SLT: signed compare; result 1 or 0, zero-extended.
  - 0101 SRL: logical right shift, zeros shifted in.
  - Any other code: result 0, completes in one cycle.
- States: IDLE, SHIFT.
- IDLE with start_in=1 at edge t0:
  - Non-shift op, or SRL with shamt=0: result_out and zero_out loaded at t0; done_out=1 for the cycle after t0; state stays IDLE.
  - SRL with shamt=N>=1: internal shift register loaded with A_in, count=N, state goes to SHIFT, busy_out=1 after t0.
- SHIFT, each edge: shift register >>1 with 0 fill, count decrements.
  - On the edge where count goes 1 to 0: result_out gets the shifted value, zero_out updates, done_out=1, busy_out=0, state returns to IDLE.
  - SRL latency: done_out is visible after edge t0+N.
- start_in while busy_out=1 is ignored; no queueing, no error flag. Operand inputs are don't-care during SHIFT.
- start_in in the same cycle that done_out=1 (state is IDLE) is accepted. Back-to-back single-cycle ops give done_out high on consecutive cycles.
- done_out is asserted exactly once per accepted start. It is never asserted without a preceding accepted start.
- result_out/zero_out change only on the done edge. They never show intermediate shift values.
- Reset mid-shift: immediately returns to IDLE with the reset values above. The in-flight operation is discarded and no done_out is issued.
- No combinational path from any input to any output.

Decomposition:
- Shared package alu_ctrl_pkg holds the 4-bit code constants: ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SRL=0101, ALU_SLT=0111. The ALU control decoder imports the same constants.
- One sub-module: alu_serial_srl (shift register, down-counter, last-shift flag; load/step inputs).
- The single-cycle datapath and the FSM stay in alu_exec_unit.

Test Plan:
- Reset: hold rst_n=0, then release -> result_out=0, zero_out=1, busy_out=0, done_out=0.
- ADD/SUB/AND/OR, one start per cycle:
  - ADD 0xFFFFFFFF+1 -> 0, zero_out=1.
  - SUB 5-7 -> 0xFFFFFFFE.
  - AND 0xF0F0 & 0x0FF0 -> 0x00F0.
  - OR with the same operands -> 0xFFF0.
  - done_out high on 4 consecutive cycles.
- SLT signed: A=0xFFFFFFFF, B=1 -> 1; A=1, B=0xFFFFFFFF -> 0 (zero_out=1).
- SRL A=0x80000000, B=31 -> busy_out=1 for 31 cycles, done_out after edge t0+31, result 0x00000001. A second start mid-shift with ADD is ignored.
- SRL with shamt=0 (B=0x20): A=0x1234 -> done after one cycle, result 0x1234. Unknown code 1111 -> result 0, done after one cycle.
- Async reset asserted mid-way through SRL B=10 -> outputs return to reset values immediately; no done_out pulse afterwards.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ALU control codes shared by the control decoder and the execute stage,
// plus the execute-stage state encoding.
package alu_ctrl_pkg;

   localparam int unsigned ALU_CTRL_W = 4;

   localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0101;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } alu_state_e;

   // Only SRL is executed by the multi-cycle serial path.
   function automatic logic is_serial_op(input logic [ALU_CTRL_W-1:0] code);
      return code == ALU_SRL;
   endfunction

endpackage

// File: rtl/alu_serial_srl.sv
// Bit-serial logical right shifter: one position per step, with a down-counter
// that flags the step which completes the requested shift.
module alu_serial_srl #(
   parameter int unsigned WIDTH = 32,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic               step_i,
   input  logic [WIDTH-1:0]   data_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic [WIDTH-1:0]   shifted_c,
   output logic               last_c
);

   logic [WIDTH-1:0]   shift_q;
   logic [SHAMT_W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         count_q <= '0;
      end else if (load_i) begin
         shift_q <= data_i;
         count_q <= shamt_i;
      end else if (step_i) begin
         shift_q <= shift_q >> 1;
         count_q <= count_q - SHAMT_W'(1);
      end
   end

   // Value the register takes on the next step; the final step's value is the result.
   assign shifted_c = shift_q >> 1;
   assign last_c    = (count_q == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arithmetic ops, bit-serial SRL, with a
// start/busy/done handshake and a result/zero pair held between completions.
module alu_exec_unit
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_in,
   input  logic [ALU_CTRL_W-1:0] ALUControl_in,
   input  logic [WIDTH-1:0]      A_in,
   input  logic [WIDTH-1:0]      B_in,
   output logic [WIDTH-1:0]      result_out,
   output logic                  zero_out,
   output logic                  busy_out,
   output logic                  done_out
);

   localparam int unsigned SHAMT_W = $clog2(WIDTH);

   alu_state_e         state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   alu_res;
   logic [SHAMT_W-1:0] shamt;
   logic               srl_load, srl_step, srl_last;
   logic [WIDTH-1:0]   srl_shifted;

   assign shamt = B_in[SHAMT_W-1:0];

   // Single-cycle datapath; SRL lands here only when the shift amount is zero.
   always_comb begin
      alu_res = '0;
      unique case (ALUControl_in)
         ALU_AND: alu_res = A_in & B_in;
         ALU_OR:  alu_res = A_in | B_in;
         ALU_ADD: alu_res = A_in + B_in;
         ALU_SUB: alu_res = A_in - B_in;
         ALU_SLT: alu_res = ($signed(A_in) < $signed(B_in)) ? WIDTH'(1) : '0;
         ALU_SRL: alu_res = A_in;
         default: alu_res = '0;
      endcase
   end

   alu_serial_srl #(.WIDTH(WIDTH)) u_srl (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (srl_load),
      .step_i    (srl_step),
      .data_i    (A_in),
      .shamt_i   (shamt),
      .shifted_c (srl_shifted),
      .last_c    (srl_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      srl_load = 1'b0;
      srl_step = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               if (is_serial_op(ALUControl_in) && (shamt != '0)) begin
                  srl_load = 1'b1;
                  busy_d   = 1'b1;
                  state_d  = ST_SHIFT;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  done_d   = 1'b1;
               end
            end
         end
         ST_SHIFT: begin
            // New starts are ignored here; operands are don't-care until done.
            srl_step = 1'b1;
            if (srl_last) begin
               result_d = srl_shifted;
               zero_d   = (srl_shifted == '0);
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign result_out = result_q;
   assign zero_out   = zero_q;
   assign busy_out   = busy_q;
   assign done_out   = done_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases with literal expectations
// plus randomized traffic compared each cycle against a latency-level model.
module tb_alu_exec_unit;
   import alu_ctrl_pkg::*;

   localparam int unsigned WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_in = 1'b0;
   logic [3:0]       ALUControl_in = 4'b0;
   logic [WIDTH-1:0] A_in = '0;
   logic [WIDTH-1:0] B_in = '0;
   logic [WIDTH-1:0] result_out;
   logic             zero_out;
   logic             busy_out;
   logic             done_out;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   // Model state: what the outputs must show after each edge.
   logic [WIDTH-1:0] m_res = '0;
   logic [WIDTH-1:0] m_pend = '0;
   logic             m_zero = 1'b1;
   logic             m_busy = 1'b0;
   logic             m_done = 1'b0;
   int               m_left = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.WIDTH(WIDTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_in      (start_in),
      .ALUControl_in (ALUControl_in),
      .A_in          (A_in),
      .B_in          (B_in),
      .result_out    (result_out),
      .zero_out      (zero_out),
      .busy_out      (busy_out),
      .done_out      (done_out)
   );

   function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      case (op)
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_ADD: return a + b;
         ALU_SUB: return a - b;
         ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SRL: return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
   endtask

   task automatic drive(input logic s, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      start_in = s;
      ALUControl_in = op;
      A_in = a;
      B_in = b;
   endtask

   // Latency-level model: an SRL of N finishes N edges after acceptance.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_res = '0; m_zero = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_res = m_pend;
               m_zero = (m_pend == '0);
               m_done = 1'b1;
            end
         end else if (start_in) begin
            if (ALUControl_in == ALU_SRL && B_in[4:0] != 5'd0) begin
               m_busy = 1'b1;
               m_left = int'(B_in[4:0]);
               m_pend = ref_alu(ALUControl_in, A_in, B_in);
            end else begin
               m_res = ref_alu(ALUControl_in, A_in, B_in);
               m_zero = (m_res == '0);
               m_done = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_result", result_out, m_res);
         check("model_zero", 32'(zero_out), 32'(m_zero));
         check("model_busy", 32'(busy_out), 32'(m_busy));
         check("model_done", 32'(done_out), 32'(m_done));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   logic [3:0]       t_op [6];
   logic [WIDTH-1:0] t_a  [6];
   logic [WIDTH-1:0] t_b  [6];
   logic [WIDTH-1:0] t_r  [6];
   logic             t_z  [6];
   logic [3:0]       r_ops [8];

   initial begin
      int lat;
      int busy_cycles;
      int done_seen;
      logic [3:0] op;
      logic [WIDTH-1:0] b;

      t_op = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLT};
      t_a  = '{32'hFFFF_FFFF, 32'd5, 32'h0000_F0F0, 32'h0000_F0F0, 32'hFFFF_FFFF, 32'd1};
      t_b  = '{32'd1, 32'd7, 32'h0000_0FF0, 32'h0000_0FF0, 32'd1, 32'hFFFF_FFFF};
      t_r  = '{32'd0, 32'hFFFF_FFFE, 32'h0000_00F0, 32'h0000_FFF0, 32'd1, 32'd0};
      t_z  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      r_ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SRL, 4'b1111, 4'b0011};

      // Reset values, during and after reset.
      repeat (3) @(negedge clk);
      check("rst_result", result_out, 32'd0);
      check("rst_zero", 32'(zero_out), 32'd1);
      check("rst_busy", 32'(busy_out), 32'd0);
      check("rst_done", 32'(done_out), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_result", result_out, 32'd0);
      check("post_rst_zero", 32'(zero_out), 32'd1);
      check("post_rst_done", 32'(done_out), 32'd0);
      chk_en = 1'b1;

      // Back-to-back single-cycle ops: done on consecutive cycles.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, t_op[i], t_a[i], t_b[i]);
         @(negedge clk);
         check($sformatf("b2b_done_%0d", i), 32'(done_out), 32'd1);
         check($sformatf("b2b_result_%0d", i), result_out, t_r[i]);
         check($sformatf("b2b_zero_%0d", i), 32'(zero_out), 32'(t_z[i]));
      end
      drive(1'b0, ALU_AND, '0, '0);
      @(negedge clk);
      check("idle_done", 32'(done_out), 32'd0);
      check("idle_hold", result_out, 32'd0);

      // Long SRL with an ADD start attempted mid-shift.
      drive(1'b1, ALU_SRL, 32'h8000_0000, 32'd31);
      @(negedge clk);
      drive(1'b1, ALU_ADD, 32'd3, 32'd4);
      lat = 1;
      busy_cycles = 0;
      while (!done_out && lat < 100) begin
         if (busy_out) busy_cycles++;
         if (lat == 2) drive(1'b0, ALU_AND, '0, '0);
         @(negedge clk);
         lat++;
      end
      check("srl31_latency", 32'(lat), 32'd32);
      check("srl31_busy_cycles", 32'(busy_cycles), 32'd31);
      check("srl31_result", result_out, 32'd1);
      check("srl31_busy_at_done", 32'(busy_out), 32'd0);
      @(negedge clk);
      check("srl31_single_done", 32'(done_out), 32'd0);
      check("srl31_add_ignored", result_out, 32'd1);

      // SRL with zero shift amount and an unknown code both finish in one cycle.
      drive(1'b1, ALU_SRL, 32'h0000_1234, 32'h0000_0020);
      @(negedge clk);
      check("srl0_done", 32'(done_out), 32'd1);
      check("srl0_busy", 32'(busy_out), 32'd0);
      check("srl0_result", result_out, 32'h0000_1234);
      drive(1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h1234_5678);
      @(negedge clk);
      check("unk_done", 32'(done_out), 32'd1);
      check("unk_result", result_out, 32'd0);
      check("unk_zero", 32'(zero_out), 32'd1);

      // Async reset in the middle of an SRL by 10.
      drive(1'b1, ALU_OR, 32'h0000_00A5, 32'd0);
      @(negedge clk);
      drive(1'b1, ALU_SRL, 32'hFFFF_0000, 32'd10);
      @(negedge clk);
      drive(1'b0, ALU_AND, '0, '0);
      repeat (4) @(negedge clk);
      check("pre_rst_busy", 32'(busy_out), 32'd1);
      check("pre_rst_result", result_out, 32'h0000_00A5);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_result", result_out, 32'd0);
      check("midrst_zero", 32'(zero_out), 32'd1);
      check("midrst_busy", 32'(busy_out), 32'd0);
      check("midrst_done", 32'(done_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done_out) done_seen++;
      end
      check("midrst_no_done", 32'(done_seen), 32'd0);

      // Randomized traffic, checked every cycle against the model.
      for (int i = 0; i < 400; i++) begin
         op = r_ops[$urandom_range(0, 7)];
         b = $urandom;
         if (op == ALU_SRL && $urandom_range(0, 1) == 0) b = 32'($urandom_range(0, 6));
         drive($urandom_range(0, 3) != 0, op, $urandom, b);
         @(negedge clk);
      end
      drive(1'b0, ALU_AND, '0, '0);
      lat = 0;
      while (busy_out && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("drain_idle", 32'(busy_out), 32'd0);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
